// File: rtl/fixed_divider_seq_if.sv
// fixed_divider_seq_if: operand/result handshake bundle for fixed_divider_seq.
//   valid_i/ready_o       operand channel (a_i dividend, b_i divisor, signed Q16.16)
//   valid_o/ready_i       result channel  (z_o quotient, div_by_zero_o, overflow_o)
// Modports: master = producer/consumer side, slave = divider side.
interface fixed_divider_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] z_o;
    logic             div_by_zero_o;
    logic             overflow_o;

    modport master (
        output valid_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, z_o, div_by_zero_o, overflow_o
    );

    modport slave (
        input  valid_i, a_i, b_i, ready_i,
        output ready_o, valid_o, z_o, div_by_zero_o, overflow_o
    );
endinterface

// File: rtl/fixed_divider_seq.sv
// fixed_divider_seq: multi-cycle exact signed Q16.16 divider, z = a / b.
// Restoring radix-2, one quotient bit per clock over WIDTH+FRAC_BITS cycles,
// then one cycle to saturate/sign the result. b == 0 bypasses the iteration.
// Ports:
//   clk        clock, rising edge
//   reset_ni   asynchronous active-low reset
//   bus        fixed_divider_seq_if.slave (operand and result handshakes)
// Build option:
//   GRAPHITE_DIV_ROUND_EN  defined: round magnitude to nearest (ties up) before
//                          saturation; undefined: truncate toward zero.
module fixed_divider_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FRAC_BITS = 16
) (
    input  logic               clk,
    input  logic               reset_ni,
    fixed_divider_seq_if.slave bus
);

    localparam int unsigned NW = WIDTH + FRAC_BITS;
    localparam int unsigned CW = $clog2(NW);

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [NW-1:0]    num;
    logic [WIDTH-1:0] den;
    logic [WIDTH-1:0] rem;
    logic [NW-1:0]    quo;
    logic             neg;
    logic             ready_q;
    logic             valid_q;
    logic [WIDTH-1:0] z_q;
    logic             dz_q;
    logic             ov_q;

    // Operand magnitudes; |most-negative| is exact as an unsigned value.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;

    always_comb begin
        a_mag  = bus.a_i[WIDTH-1] ? WIDTH'(-bus.a_i) : bus.a_i;
        b_mag  = bus.b_i[WIDTH-1] ? WIDTH'(-bus.b_i) : bus.b_i;
        b_zero = (bus.b_i == '0);
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [WIDTH:0]   rem_sh;
    logic             sub_ok;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        rem_sh   = {rem, num[NW-1]};
        sub_ok   = (rem_sh >= {1'b0, den});
        rem_next = sub_ok ? WIDTH'(rem_sh - {1'b0, den}) : rem_sh[WIDTH-1:0];
    end

    // Final magnitude, saturation and sign application.
    logic [NW-1:0]    mag;
    logic             over;
    logic [WIDTH-1:0] z_fix;

    always_comb begin
`ifdef GRAPHITE_DIV_ROUND_EN
        // Remainder >= D/2 rounds the magnitude up (ties away from zero).
        mag = quo + NW'({rem, 1'b0} >= {1'b0, den});
`else
        mag = quo;
`endif
        over  = neg ? (mag > NW'(NEG_MIN)) : (mag > NW'(POS_MAX));
        z_fix = mag[WIDTH-1:0];
        if (over) begin
            z_fix = neg ? NEG_MIN : POS_MAX;
        end else if (neg) begin
            // Negating a zero magnitude yields +0 naturally.
            z_fix = WIDTH'(-mag[WIDTH-1:0]);
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= S_IDLE;
            cnt     <= '0;
            num     <= '0;
            den     <= '0;
            rem     <= '0;
            quo     <= '0;
            neg     <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            z_q     <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        ready_q <= 1'b0;
                        neg     <= bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1];
                        if (b_zero) begin
                            // Result is known now; valid_o follows one cycle later in DONE.
                            z_q   <= bus.a_i[WIDTH-1] ? NEG_MIN : POS_MAX;
                            dz_q  <= 1'b1;
                            ov_q  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            num   <= {a_mag, FRAC_BITS'(0)};
                            den   <= b_mag;
                            rem   <= '0;
                            quo   <= '0;
                            cnt   <= '0;
                            state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    rem <= rem_next;
                    quo <= {quo[NW-2:0], sub_ok};
                    num <= num << 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NW - 1)) begin
                        state <= S_FIX;
                    end
                end

                S_FIX: begin
                    z_q     <= z_fix;
                    ov_q    <= over;
                    dz_q    <= 1'b0;
                    valid_q <= 1'b1;
                    state   <= S_DONE;
                end

                S_DONE: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (bus.ready_i) begin
                        // ready_o returns on the cycle after the result is taken.
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o       = ready_q;
    assign bus.valid_o       = valid_q;
    assign bus.z_o           = z_q;
    assign bus.div_by_zero_o = dz_q;
    assign bus.overflow_o    = ov_q;

endmodule
